// File: rtl/v2k_pkg.sv
// Shared constants and sizing helpers for the v2k receive-side blocks.
package v2k_pkg;

    localparam int V2K_WIDTH = 16;
    localparam int V2K_DEPTH = 4;

    // Pointer width for a DEPTH-entry buffer; the level counter is one bit wider.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/v2k_fifo_ptr.sv
// Wrapping FIFO pointer: clears on reset, advances by one when inc is high.
module v2k_fifo_ptr #(
    parameter int PW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Pointer register; wraps DEPTH-1 -> 0 through natural overflow.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= ptr + PW'(1);
        end
    end

endmodule

// File: rtl/v2k_sink_fifo.sv
// Receive-side FIFO for the registered v2k word stream: valid/ready on both
// sides, fill level output and a sticky overflow-attempt error flag.
module v2k_sink_fifo
    import v2k_pkg::*;
#(
    parameter int WIDTH = V2K_WIDTH,
    parameter int DEPTH = V2K_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WIDTH:0]              in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH:0]              out_data,
    output logic [ptr_width(DEPTH):0]   level,
    output logic                        err
);

    localparam int PW = ptr_width(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH:0] mem [DEPTH];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic           push;
    logic           pop;

    // Flow control derives only from the registered level, so a pop never
    // opens in_ready in the same cycle (no pass-through path).
    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    v2k_fifo_ptr #(.PW(PW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push),
        .ptr (wr_ptr)
    );

    v2k_fifo_ptr #(.PW(PW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop),
        .ptr (rd_ptr)
    );

    // Storage write on an accepted push.
    // NOTE: the array has no reset; the pointers and level are cleared
    // instead, which logically discards whatever the entries still hold.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Fill level: +1 on push only, -1 on pop only, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            level <= '0;
        end else begin
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Sticky error: producer offered a word while the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (in_valid && !in_ready) begin
            err <= 1'b1;
        end
    end

    // Oldest word, forced to zero while nothing is stored.
    // NOTE: every output of a combinational block gets a value on every path
    // (default first) so no latch is inferred.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_v2k_sink_fifo.sv
// Self-checking bench for v2k_sink_fifo: directed vectors plus a random-stall
// run, with a queue-based scoreboard and a negedge monitor.
module tb_v2k_sink_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int N_RND = 1000;

    logic             clk       = 1'b0;
    logic             rst       = 1'b1;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH:0]   in_data   = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH:0]   out_data;
    logic [LW-1:0]    level;
    logic             err;

    int tests = 0;
    int fails = 0;

    // Scoreboard state, owned by the monitor process.
    logic [WIDTH:0] exp_q[$];
    int             m_level  = 0;
    logic           m_err    = 1'b0;
    int             rx_count = 0;

    v2k_sink_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: compares DUT outputs mid-cycle, then records the
    // transfers that the coming edge will perform.
    always @(negedge clk) begin
        if (rst) begin
            m_level = 0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            bit push_ok;
            bit pop_ok;
            check("level", 32'(level), 32'(m_level));
            check("in_ready", 32'(in_ready), 32'(m_level != DEPTH));
            check("out_valid", 32'(out_valid), 32'(m_level != 0));
            check("err", 32'(err), 32'(m_err));
            if (m_level == 0) check("out_data_empty", 32'(out_data), 32'(0));
            else              check("out_data_order", 32'(out_data), 32'(exp_q[0]));
            push_ok = in_valid && (m_level != DEPTH);
            pop_ok  = out_ready && (m_level != 0);
            if (in_valid && m_level == DEPTH) m_err = 1'b1;
            if (pop_ok) begin
                void'(exp_q.pop_front());
                rx_count++;
            end
            if (push_ok) exp_q.push_back(in_data);
            m_level = m_level + int'(push_ok) - int'(pop_ok);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic pop_expect(input logic [WIDTH:0] d);
        check("pop_data", 32'(out_data), 32'(d));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int sent;
        int rx_target;
        int cyc;

        step();
        step();
        rst = 1'b0;

        // Reset with two words stored and a push in flight.
        push(17'h00011);
        push(17'h00022);
        check("pre_reset_level", 32'(level), 32'd2);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 17'h00033;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_level", 32'(level), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_err", 32'(err), 32'd0);

        // Single word: one-cycle latency, then popped.
        push(17'h1A5A5);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h1A5A5);
        check("single_level", 32'(level), 32'd1);
        pop_expect(17'h1A5A5);
        check("single_drained_valid", 32'(out_valid), 32'd0);
        check("single_drained_data", 32'(out_data), 32'd0);

        // Fill, partial drain, refill across the pointer wrap.
        for (int i = 0; i < 4; i++) push(17'(i));
        check("full_level", 32'(level), 32'd4);
        check("full_in_ready", 32'(in_ready), 32'd0);
        pop_expect(17'd0);
        pop_expect(17'd1);
        check("after_pop_in_ready", 32'(in_ready), 32'd1);
        push(17'd4);
        push(17'd5);
        check("refill_level", 32'(level), 32'd4);
        for (int i = 2; i < 6; i++) pop_expect(17'(i));
        check("wrap_empty_level", 32'(level), 32'd0);

        // Simultaneous push and pop at level 2.
        push(17'h0010);
        push(17'h0011);
        in_valid  = 1'b1;
        in_data   = 17'h0012;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("pushpop_level", 32'(level), 32'd2);
        check("pushpop_head", 32'(out_data), 32'h0011);

        // At full, push+pop offered: only the pop happens, err sets.
        push(17'h0013);
        push(17'h0014);
        check("full2_level", 32'(level), 32'd4);
        in_valid  = 1'b1;
        in_data   = 17'h0015;
        out_ready = 1'b1;
        step();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("full_pop_level", 32'(level), 32'd3);
        check("full_pop_err", 32'(err), 32'd1);
        check("full_pop_in_ready", 32'(in_ready), 32'd1);
        pop_expect(17'h0012);
        pop_expect(17'h0013);
        pop_expect(17'h0014);
        check("sticky_err_empty", 32'(err), 32'd1);

        // Overflow: five back-to-back words into an empty FIFO, no pops.
        do_reset();
        check("ovf_err_cleared", 32'(err), 32'd0);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 17'h00020 + 17'(i);
            step();
            if (i == 3) check("ovf_err_before", 32'(err), 32'd0);
        end
        in_valid = 1'b0;
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_level", 32'(level), 32'd4);
        step();
        step();
        check("ovf_err_sticky", 32'(err), 32'd1);
        for (int i = 0; i < 4; i++) pop_expect(17'h00020 + 17'(i));
        check("ovf_drained_level", 32'(level), 32'd0);
        check("ovf_err_still", 32'(err), 32'd1);
        do_reset();
        check("ovf_err_reset", 32'(err), 32'd0);

        // Random stalls on both sides; producer honours in_ready.
        sent      = 0;
        rx_target = rx_count + N_RND;
        cyc       = 0;
        while ((sent < N_RND || rx_count < rx_target) && cyc < 20000) begin
            in_valid  = (sent < N_RND) && in_ready && ($urandom_range(0, 1) == 1);
            in_data   = 17'($urandom);
            out_ready = ($urandom_range(0, 1) == 1);
            if (in_valid) sent++;
            step();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rnd_all_received", 32'(rx_count), 32'(rx_target));
        check("rnd_level_zero", 32'(level), 32'd0);
        check("rnd_err", 32'(err), 32'd0);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
